// File: rtl/ft245_pkg.sv
`timescale 1ns/1ps
// Shared constants for the FT245-style synchronous FIFO device:
// default FIFO depth, byte width and the err bit positions.
package ft245_pkg;
  localparam int DEPTH_DEFAULT = 16;
  localparam int BYTE_W        = 8;
  localparam int ERR_W         = 3;
  localparam int ERR_WR_FULL   = 0;
  localparam int ERR_RD_NO_OE  = 1;
  localparam int ERR_OE_WR     = 2;
endpackage

// File: rtl/ft245_sync_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through synchronous FIFO with an occupancy count and a
// look-ahead count_next, so the owner can register flags from post-edge occupancy.
module sync_fifo
  import ft245_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  parameter  int W     = BYTE_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // The FIFO protects itself against overflow/underflow even if the owner does not.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ft245_device.sv
`timescale 1ns/1ps
// FT245-style synchronous FIFO device: host side uses active-low strobes on a
// bidirectional byte bus, PC side uses valid/ready streams into and out of two FIFOs.
module ft245_device
  import ft245_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              _txe,
  output logic              _rxf,
  input  logic              _rd,
  input  logic              _wr,
  input  logic              _oe,
  inout  wire  [BYTE_W-1:0] data,
  input  logic [BYTE_W-1:0] pc_tx_data,
  input  logic              pc_tx_valid,
  output logic              pc_tx_ready,
  output logic [BYTE_W-1:0] pc_rx_data,
  output logic              pc_rx_valid,
  input  logic              pc_rx_ready,
  output logic [ERR_W-1:0]  err
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]     rd_count;
  logic [CW-1:0]     rd_count_next;
  logic [CW-1:0]     wr_count;
  logic [CW-1:0]     wr_count_next;
  logic [BYTE_W-1:0] rd_head;
  logic              oe_q;
  logic              host_rd;
  logic              host_wr;
  logic              tx_push;
  logic              rx_pop;
  logic [ERR_W-1:0]  err_set;

  // Host strobes are only honoured when the registered flag for that direction allows them.
  assign host_rd = !_rd && !_oe && !_rxf;
  assign host_wr = !_wr && !_txe;

  // PC streams: a beat transfers on any edge where valid and ready are both high;
  // ready/valid never depend on the partner's valid/ready in the same cycle.
  assign pc_tx_ready = (rd_count != FULL_CNT);
  assign tx_push     = pc_tx_valid && pc_tx_ready;
  assign pc_rx_valid = (wr_count != '0);
  assign rx_pop      = pc_rx_valid && pc_rx_ready;

  assign data = (!_oe && (rd_count != '0)) ? rd_head : {BYTE_W{1'bz}};

  always_comb begin
    err_set               = '0;
    err_set[ERR_WR_FULL]  = !_wr && _txe;
    err_set[ERR_RD_NO_OE] = !_rd && (oe_q || _oe);
    err_set[ERR_OE_WR]    = !_oe && !_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      _rxf <= 1'b1;
      _txe <= 1'b0;
      oe_q <= 1'b1;
      err  <= '0;
    end else begin
      _rxf <= (rd_count_next == '0);
      _txe <= (wr_count_next == FULL_CNT);
      oe_q <= _oe;
      err  <= err | err_set;
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_rd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (tx_push),
    .push_data  (pc_tx_data),
    .pop        (host_rd),
    .head       (rd_head),
    .count      (rd_count),
    .count_next (rd_count_next)
  );

  sync_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_wr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (host_wr),
    .push_data  (data),
    .pop        (rx_pop),
    .head       (pc_rx_data),
    .count      (wr_count),
    .count_next (wr_count_next)
  );
endmodule

// File: tb/tb_ft245_device.sv
`timescale 1ns/1ps
// Bench for ft245_device: a directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_ft245_device;
  import ft245_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       rd_n, wr_n, oe_n;
  logic       host_drive;
  logic [7:0] host_data;
  logic [7:0] pc_tx_data;
  logic       pc_tx_valid;
  logic       pc_tx_ready;
  logic [7:0] pc_rx_data;
  logic       pc_rx_valid;
  logic       pc_rx_ready;
  logic       txe_n, rxf_n;
  logic [2:0] err;
  tri1  [7:0] data;

  // Undriven bus reads back as 0xFF; stimulus bytes never use 0xFF.
  assign data = host_drive ? host_data : 8'hzz;

  always #5 clk = ~clk;

  ft245_device #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    ._txe        (txe_n),
    ._rxf        (rxf_n),
    ._rd         (rd_n),
    ._wr         (wr_n),
    ._oe         (oe_n),
    .data        (data),
    .pc_tx_data  (pc_tx_data),
    .pc_tx_valid (pc_tx_valid),
    .pc_tx_ready (pc_tx_ready),
    .pc_rx_data  (pc_rx_data),
    .pc_rx_valid (pc_rx_valid),
    .pc_rx_ready (pc_rx_ready),
    .err         (err)
  );

  // ---------------- scoreboard / reference model ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic [2:0] err_m = 3'b000;
  logic       oe_prev_m = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int   rs;
    int   ws;
    logic rd_ok, wr_ok, tx_ok, rx_ok;
    rs = rd_q.size();
    ws = exp_q.size();
    if (reset) begin
      rd_q.delete();
      exp_q.delete();
      err_m     = 3'b000;
      oe_prev_m = 1'b1;
      return;
    end
    rd_ok = !rd_n && !oe_n && (rs > 0);
    wr_ok = !wr_n && (ws < DEPTH);
    tx_ok = pc_tx_valid && (rs < DEPTH);
    rx_ok = pc_rx_ready && (ws > 0);
    if (!wr_n && ws == DEPTH)        err_m[0] = 1'b1;
    if (!rd_n && (oe_prev_m || oe_n)) err_m[1] = 1'b1;
    if (!oe_n && !wr_n)              err_m[2] = 1'b1;
    if (rd_ok) void'(rd_q.pop_front());
    if (tx_ok) rd_q.push_back(pc_tx_data);
    if (rx_ok) void'(exp_q.pop_front());
    if (wr_ok) exp_q.push_back(host_data);
    oe_prev_m = oe_n;
  endtask

  function automatic logic [7:0] exp_data();
    if (!oe_n && rd_q.size() > 0) return rd_q[0];
    if (host_drive) return host_data;
    return 8'hFF;
  endfunction

  task automatic compare_model();
    check("rnd_rxf", rxf_n, rd_q.size() == 0);
    check("rnd_txe", txe_n, exp_q.size() == DEPTH);
    check("rnd_tx_ready", pc_tx_ready, rd_q.size() < DEPTH);
    check("rnd_rx_valid", pc_rx_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("rnd_rx_data", pc_rx_data, exp_q[0]);
    check("rnd_data", data, exp_data());
    check("rnd_err", err, err_m);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    reset       = 1'b0;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    oe_n        = 1'b1;
    host_drive  = 1'b0;
    host_data   = 8'h00;
    pc_tx_valid = 1'b0;
    pc_tx_data  = 8'h00;
    pc_rx_ready = 1'b0;
  endtask

  task automatic reset_dut();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, rd_n, wr_n, oe_n;
    logic [7:0] hdata;
    logic       tx_v;
    logic [7:0] tx_d;
    logic       rx_r;
    logic       e_rxf, e_txe;
    logic [7:0] e_data;
    logic [2:0] e_err;
    logic       e_rx_v, e_tx_r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdn, logic wrn, logic oen, logic [7:0] hd,
                              logic txv, logic [7:0] txd, logic rxr, logic erxf, logic etxe,
                              logic [7:0] edat, logic [2:0] eerr, logic erxv, logic etxr);
    vec_t v;
    v.rst = rst; v.rd_n = rdn; v.wr_n = wrn; v.oe_n = oen; v.hdata = hd;
    v.tx_v = txv; v.tx_d = txd; v.rx_r = rxr;
    v.e_rxf = erxf; v.e_txe = etxe; v.e_data = edat; v.e_err = eerr;
    v.e_rx_v = erxv; v.e_tx_r = etxr;
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    set_idle();
    repeat (2) @(posedge clk);
    #1;

    //                 rst rd wr oe hdata tx txd   rx | rxf txe data  err  rxv txr
    vecs.push_back(mk(1, 1, 1, 1, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'hA5, 0,  0, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h3C, 0,  0, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 8'hA5, 3'b000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h3C, 3'b000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h11, 0,  0, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 8'h00, 0,  0, 0, 8'hFF, 3'b010, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h11, 3'b010, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h22, 0,  0, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h33, 0,  0, 0, 8'hFF, 3'b000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 8'h33, 3'b010, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0,  1, 0, 8'hFF, 3'b010, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'h5E, 0, 8'h00, 0,  1, 0, 8'h5E, 3'b010, 1, 1));

    foreach (vecs[k]) begin
      reset       = vecs[k].rst;
      rd_n        = vecs[k].rd_n;
      wr_n        = vecs[k].wr_n;
      oe_n        = vecs[k].oe_n;
      host_drive  = !vecs[k].wr_n;
      host_data   = vecs[k].hdata;
      pc_tx_valid = vecs[k].tx_v;
      pc_tx_data  = vecs[k].tx_d;
      pc_rx_ready = vecs[k].rx_r;
      tick();
      check($sformatf("vec%0d_rxf", k), rxf_n, vecs[k].e_rxf);
      check($sformatf("vec%0d_txe", k), txe_n, vecs[k].e_txe);
      check($sformatf("vec%0d_data", k), data, vecs[k].e_data);
      check($sformatf("vec%0d_err", k), err, vecs[k].e_err);
      check($sformatf("vec%0d_rx_valid", k), pc_rx_valid, vecs[k].e_rx_v);
      check($sformatf("vec%0d_tx_ready", k), pc_tx_ready, vecs[k].e_tx_r);
    end

    // Host fills the write FIFO, overflows once, then the PC drains in order.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      wr_n = 1'b0; host_drive = 1'b1; host_data = 8'(i);
      tick();
      check($sformatf("fill_txe_%0d", i), txe_n, (i == 15));
    end
    host_data = 8'h10;
    tick();
    check("overflow_err0", err[0], 1'b1);
    check("overflow_txe", txe_n, 1'b1);
    wr_n = 1'b1; host_drive = 1'b0; pc_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_valid_%0d", i), pc_rx_valid, 1'b1);
      check($sformatf("drain_data_%0d", i), pc_rx_data, 8'(i));
      tick();
    end
    pc_rx_ready = 1'b0;
    check("drain_empty", pc_rx_valid, 1'b0);
    check("drain_txe", txe_n, 1'b0);

    // Full write FIFO with PC pop and host write on the same edge: the write is
    // refused because _txe was high; then push+pop together keep the count.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      wr_n = 1'b0; host_drive = 1'b1; host_data = 8'(8'h40 + i);
      tick();
    end
    check("full_txe", txe_n, 1'b1);
    pc_rx_ready = 1'b1; host_data = 8'h99;
    tick();
    check("full_pop_err0", err[0], 1'b1);
    check("full_pop_txe", txe_n, 1'b0);
    check("full_pop_head", pc_rx_data, 8'h41);
    host_data = 8'h77;
    tick();
    check("pushpop_txe", txe_n, 1'b0);
    check("pushpop_head", pc_rx_data, 8'h42);
    pc_rx_ready = 1'b0; host_data = 8'h88;
    tick();
    check("refill_txe", txe_n, 1'b1);
    wr_n = 1'b1; host_drive = 1'b0; pc_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i < 14) ? 8'(8'h42 + i) : ((i == 14) ? 8'h77 : 8'h88);
      check($sformatf("order_%0d", i), pc_rx_data, e);
      tick();
    end
    pc_rx_ready = 1'b0;
    check("order_empty", pc_rx_valid, 1'b0);

    // Reset in the middle of an active host read with both FIFOs holding bytes.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      pc_tx_valid = 1'b1; pc_tx_data = 8'(8'h50 + i);
      wr_n = 1'b0; host_drive = 1'b1; host_data = 8'(8'h60 + i);
      tick();
    end
    pc_tx_valid = 1'b0; wr_n = 1'b1; host_drive = 1'b0; oe_n = 1'b0;
    tick();
    check("midrd_data0", data, 8'h50);
    rd_n = 1'b0;
    tick();
    check("midrd_data1", data, 8'h51);
    check("midrd_rx_valid", pc_rx_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rxf", rxf_n, 1'b1);
    check("rst_txe", txe_n, 1'b0);
    check("rst_rx_valid", pc_rx_valid, 1'b0);
    check("rst_data", data, 8'hFF);
    check("rst_tx_ready", pc_tx_ready, 1'b1);
    check("rst_err", err, 3'b000);
    rd_n = 1'b1;
    tick();
    check("post_rst_rxf", rxf_n, 1'b1);
    check("post_rst_data", data, 8'hFF);

    // _oe and _wr low together: flagged, byte still stored.
    reset_dut();
    oe_n = 1'b0; wr_n = 1'b0; host_drive = 1'b1; host_data = 8'h6B;
    tick();
    set_idle();
    #1;
    check("oewr_err", err, 3'b100);
    check("oewr_rx_valid", pc_rx_valid, 1'b1);
    check("oewr_rx_data", pc_rx_data, 8'h6B);

    // Randomized traffic in phases biased toward filling, draining and mixed load.
    reset_dut();
    for (int blk = 0; blk < 4; blk++) begin
      int p_tx, p_rd, p_wr, p_rx;
      case (blk)
        0:       begin p_tx = 85; p_rd = 15; p_wr = 90; p_rx = 5;  end
        1:       begin p_tx = 15; p_rd = 85; p_wr = 20; p_rx = 80; end
        2:       begin p_tx = 50; p_rd = 50; p_wr = 60; p_rx = 40; end
        default: begin p_tx = 95; p_rd = 95; p_wr = 95; p_rx = 95; end
      endcase
      for (int c = 0; c < 200; c++) begin
        reset       = ($urandom_range(99) == 0);
        oe_n        = ($urandom_range(99) >= 60);
        rd_n        = !($urandom_range(99) < p_rd);
        wr_n        = oe_n ? !($urandom_range(99) < p_wr) : 1'b1;
        host_drive  = !wr_n;
        host_data   = 8'($urandom_range(254));
        pc_tx_valid = ($urandom_range(99) < p_tx);
        pc_tx_data  = 8'($urandom_range(254));
        pc_rx_ready = ($urandom_range(99) < p_rx);
        tick();
        compare_model();
      end
    end

    set_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
